// File: rtl/ec_datapath.sv
// Accumulator-machine datapath: PC, IR, accumulator A, unified instruction/data RAM
// and an add/sub ALU, with a RAM loader port that takes over while prog_mode is high.
module ec_datapath #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8   // must equal ADDR_W+3: opcode[2:0] above an ADDR_W address
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              IRload,
  input  logic              JMPmux,
  input  logic              PCload,
  input  logic              Meminst,
  input  logic              MemWr,
  input  logic              Aload,
  input  logic              Sub,
  input  logic [1:0]        Asel,
  input  logic [DATA_W-1:0] Input,
  input  logic              prog_mode,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [2:0]        IR,
  output logic              Aeq0,
  output logic              Apos,
  output logic [DATA_W-1:0] A_out,
  output logic [ADDR_W-1:0] PC_out
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [DATA_W-1:0] ir_reg;
  logic [DATA_W-1:0] a_reg, a_next;
  logic [DATA_W-1:0] alu_result;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              cpu_en;

  // Asynchronous read keeps fetch and single-cycle load/add/sub in one clock.
  logic [DATA_W-1:0] mem [DEPTH];

  assign cpu_en    = ~prog_mode;
  assign mem_addr  = Meminst ? ir_reg[ADDR_W-1:0] : pc_reg;
  assign mem_rdata = mem[mem_addr];

  assign alu_result = Sub ? (a_reg - mem_rdata) : (a_reg + mem_rdata);

  always_comb begin
    a_next = alu_result;
    unique case (Asel)
      2'b00:   a_next = alu_result;
      2'b01:   a_next = Input;
      2'b10:   a_next = mem_rdata;
      default: a_next = '0;
    endcase
  end

  always_comb begin
    pc_next = pc_reg + ADDR_W'(1);
    if (JMPmux) begin
      pc_next = ir_reg[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_reg <= '0;
      ir_reg <= '0;
      a_reg  <= '0;
    end else if (cpu_en) begin
      if (PCload) begin
        pc_reg <= pc_next;
      end
      if (IRload) begin
        ir_reg <= mem_rdata;
      end
      if (Aload) begin
        a_reg <= a_next;
      end
    end
  end

  // RAM has no reset; a write coinciding with reset is dropped. Loader wins over CPU.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (prog_mode) begin
        if (prog_we) begin
          mem[prog_addr] <= prog_data;
        end
      end else if (MemWr) begin
        mem[mem_addr] <= a_reg;
      end
    end
  end

  assign IR     = ir_reg[DATA_W-1:DATA_W-3];
  assign Aeq0   = (a_reg == '0);
  assign Apos   = ~a_reg[DATA_W-1] & (a_reg != '0);
  assign A_out  = a_reg;
  assign PC_out = pc_reg;

endmodule
